// File: rtl/ped_pkg.sv
// Shared types, constants and helpers for the Pedersen integer-to-field front end.
// Contents: field size and modulus, request mode typedef, wcode encodings,
// engine state encoding, and the integer width decode.
package ped_pkg;

    localparam int FIELD_SIZE = 253;
    localparam logic [FIELD_SIZE-1:0] FIELD_MOD =
        FIELD_SIZE'(256'h12ab655e9a2ca55660b44d1e5c37b00159aa76fed00000010a11800000000001);

    // Leaf index width: enough for bit positions 0..127.
    localparam int IDX_W = 7;

    typedef logic [2:0] wcode_t;

    // Request mode as it appears on i_mode: {signed, wcode}.
    typedef struct packed {
        logic   sgn;
        wcode_t wcode;
    } mode_t;

    localparam wcode_t WCODE_8   = 3'd0;
    localparam wcode_t WCODE_16  = 3'd1;
    localparam wcode_t WCODE_32  = 3'd2;
    localparam wcode_t WCODE_64  = 3'd3;
    localparam wcode_t WCODE_128 = 3'd4;

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_t;

    // Integer width selected by wcode; anything wider than max_bits, or an
    // undefined code, collapses to max_bits.
    function automatic int width_from_wcode(input wcode_t wcode, input int max_bits);
        int n;
        case (wcode)
            WCODE_8:   n = 8;
            WCODE_16:  n = 16;
            WCODE_32:  n = 32;
            WCODE_64:  n = 64;
            WCODE_128: n = 128;
            default:   n = max_bits;
        endcase
        if (n > max_bits) begin
            n = max_bits;
        end
        return n;
    endfunction

endpackage

// File: rtl/ped_req_fifo.sv
// Request FIFO for ped_bitdec_fifo.
// DEPTH x WIDTH synchronous FIFO with the head entry visible combinationally.
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_push, i_data  write request; ignored while full (no bypass through a same-edge pop)
//   i_pop           remove head entry; ignored while empty
//   o_head          current head entry (undefined while empty)
//   o_full, o_empty occupancy flags
module ped_req_fifo #(
    parameter int WIDTH = 68,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign o_full  = (count_q == (AW+1)'(DEPTH));
    assign o_empty = (count_q == '0);
    assign o_head  = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = i_push & ~o_full;
        do_pop   = i_pop & ~o_empty;
        // DEPTH is a power of two, so plain pointer overflow wraps modulo DEPTH.
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    // NOTE: only the pointers and count are reset; storage is never read
    // before it is written, so leaving the array unreset keeps it plain RAM.
    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/ped_bitdec_fifo.sv
// Integer-to-field front end for the Pedersen datapath.
// Each buffered request yields one result beat (the integer as a field element)
// and N leaf beats (its bits as 0/1 field elements, LSB first, o_last on bit N-1).
// Ports:
//   i_clk, i_rst_n                  clock, asynchronous active-low reset
//   i_vld, i_a, i_mode, o_rdy       request channel; i_mode = {signed, wcode}
//   o_res_vld, i_res_rdy, o_res     result channel
//   o_lvs_vld, i_lvs_rdy, o_lvs,
//   o_lvs_idx, o_last               leaf channel
module ped_bitdec_fifo #(
    parameter int MAX_BITS   = 64,
    parameter int DEPTH      = 4,
    parameter int FIELD_SIZE = ped_pkg::FIELD_SIZE
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_vld,
    input  logic [MAX_BITS-1:0]   i_a,
    input  logic [3:0]            i_mode,
    output logic                  o_rdy,
    input  logic                  i_res_rdy,
    output logic                  o_res_vld,
    output logic [FIELD_SIZE-1:0] o_res,
    input  logic                  i_lvs_rdy,
    output logic                  o_lvs_vld,
    output logic [FIELD_SIZE-1:0] o_lvs,
    output logic [6:0]            o_lvs_idx,
    output logic                  o_last
);
    import ped_pkg::*;

    localparam int DW = MAX_BITS + 4;
    localparam logic [FIELD_SIZE-1:0] MOD_W = FIELD_SIZE'(FIELD_MOD);

    // ---------------- request FIFO ----------------
    logic [DW-1:0]       fifo_head;
    logic                fifo_full, fifo_empty;
    logic                load;
    mode_t               head_mode;
    logic [MAX_BITS-1:0] head_a;

    ped_req_fifo #(
        .WIDTH (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (i_vld),
        .i_data  ({i_mode, i_a}),
        .i_pop   (load),
        .o_head  (fifo_head),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    assign o_rdy = ~fifo_full;
    assign {head_mode, head_a} = fifo_head;

    // ---------------- head decode ----------------
    // Work at field width so 2^N is representable even for N = 128.
    int                    head_n;
    logic [FIELD_SIZE-1:0] head_pow2, head_at, head_top, head_res;
    logic [IDX_W-1:0]      head_last_idx;

    always_comb begin
        head_n        = width_from_wcode(head_mode.wcode, MAX_BITS);
        head_pow2     = FIELD_SIZE'(1) << head_n;
        head_at       = FIELD_SIZE'(head_a) & (head_pow2 - FIELD_SIZE'(1));
        head_top      = head_at >> (head_n - 1);
        head_last_idx = IDX_W'(head_n - 1);
        // A negative value -(2^N - at) maps to FIELD_MOD minus its magnitude.
        if (head_mode.sgn && head_top[0]) begin
            head_res = MOD_W - (head_pow2 - head_at);
        end else begin
            head_res = head_at;
        end
    end

    // ---------------- engine ----------------
    state_t                state_q, state_d;
    logic [FIELD_SIZE-1:0] res_q, res_d;
    logic [MAX_BITS-1:0]   at_q, at_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [IDX_W-1:0]      last_idx_q, last_idx_d;
    logic                  res_vld_q, res_vld_d;
    logic                  lvs_vld_q, lvs_vld_d;
    logic                  res_fire, lvs_fire, leaf_last, finishing;
    logic [MAX_BITS-1:0]   at_shift;

    always_comb begin
        state_d    = state_q;
        res_d      = res_q;
        at_d       = at_q;
        idx_d      = idx_q;
        last_idx_d = last_idx_q;
        res_vld_d  = res_vld_q;
        lvs_vld_d  = lvs_vld_q;

        res_fire  = res_vld_q & i_res_rdy;
        lvs_fire  = lvs_vld_q & i_lvs_rdy;
        leaf_last = (idx_q == last_idx_q);
        // Done when each channel is either already finished or finishes now.
        finishing = (state_q == S_BUSY)
                  & (~res_vld_q | res_fire)
                  & (~lvs_vld_q | (lvs_fire & leaf_last));
        // Loading on the finishing edge gives back-to-back requests with no bubble.
        load      = ~fifo_empty & ((state_q == S_IDLE) | finishing);

        if (res_fire) begin
            res_vld_d = 1'b0;
        end
        if (lvs_fire) begin
            // The index parks on N-1 so the leaf select never runs past the data.
            if (leaf_last) begin
                lvs_vld_d = 1'b0;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end

        if (finishing) begin
            state_d    = S_IDLE;
            res_d      = '0;
            at_d       = '0;
            idx_d      = '0;
            last_idx_d = '0;
        end

        if (load) begin
            state_d    = S_BUSY;
            res_d      = head_res;
            at_d       = head_at[MAX_BITS-1:0];
            idx_d      = '0;
            last_idx_d = head_last_idx;
            res_vld_d  = 1'b1;
            lvs_vld_d  = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            res_q      <= '0;
            at_q       <= '0;
            idx_q      <= '0;
            last_idx_q <= '0;
            res_vld_q  <= 1'b0;
            lvs_vld_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            res_q      <= res_d;
            at_q       <= at_d;
            idx_q      <= idx_d;
            last_idx_q <= last_idx_d;
            res_vld_q  <= res_vld_d;
            lvs_vld_q  <= lvs_vld_d;
        end
    end

    assign at_shift  = at_q >> idx_q;
    assign o_res_vld = res_vld_q;
    assign o_res     = res_q;
    assign o_lvs_vld = lvs_vld_q;
    assign o_lvs     = FIELD_SIZE'(at_shift[0] & lvs_vld_q);
    assign o_lvs_idx = idx_q;
    assign o_last    = lvs_vld_q & leaf_last;

endmodule

// File: tb/tb_ped_bitdec_fifo.sv
// Self-checking bench for ped_bitdec_fifo (MAX_BITS=64, DEPTH=4).
// Expected result and leaf beats are queued when a request is accepted and
// compared by a monitor when the DUT completes the corresponding beat.
module tb_ped_bitdec_fifo;
    import ped_pkg::*;

    localparam int MB = 64;
    localparam logic [252:0] MOD = 253'(256'h12ab655e9a2ca55660b44d1e5c37b00159aa76fed00000010a11800000000001);

    typedef struct {
        logic       b;
        logic [6:0] idx;
        logic       last;
    } leaf_t;

    logic           clk;
    logic           rst_n;
    logic           i_vld;
    logic [MB-1:0]  i_a;
    logic [3:0]     i_mode;
    logic           o_rdy;
    logic           i_res_rdy;
    logic           o_res_vld;
    logic [252:0]   o_res;
    logic           i_lvs_rdy;
    logic           o_lvs_vld;
    logic [252:0]   o_lvs;
    logic [6:0]     o_lvs_idx;
    logic           o_last;

    int checks = 0;
    int errors = 0;
    int res_beats = 0;
    int lvs_beats = 0;
    bit rand_en = 0;

    logic [252:0] res_sb[$];
    leaf_t        lvs_sb[$];

    ped_bitdec_fifo #(
        .MAX_BITS   (MB),
        .DEPTH      (4),
        .FIELD_SIZE (253)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_vld     (i_vld),
        .i_a       (i_a),
        .i_mode    (i_mode),
        .o_rdy     (o_rdy),
        .i_res_rdy (i_res_rdy),
        .o_res_vld (o_res_vld),
        .o_res     (o_res),
        .i_lvs_rdy (i_lvs_rdy),
        .o_lvs_vld (o_lvs_vld),
        .o_lvs     (o_lvs),
        .o_lvs_idx (o_lvs_idx),
        .o_last    (o_last)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Independent reference for the signed/unsigned mapping.
    function automatic logic [252:0] exp_result(input logic [63:0] a, input logic sgn, input int n);
        logic [255:0] pow2, at;
        pow2 = 256'd1 << n;
        at   = {192'd0, a} & (pow2 - 256'd1);
        if (sgn && at[n-1]) return 253'(MOD - 253'(pow2 - at));
        return 253'(at);
    endfunction

    // Randomised ready pattern, applied just after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_en) begin
                i_res_rdy = 1'($urandom_range(0, 1));
                i_lvs_rdy = 1'($urandom_range(0, 1));
            end
        end
    end

    // Monitor: a beat is seen mid-cycle with vld & rdy, and completes at the next edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_res_vld && i_res_rdy) begin
                res_beats++;
                if (res_sb.size() == 0) begin
                    check("res_unexpected", 1, 0);
                end else begin
                    check("res_value", o_res, res_sb.pop_front());
                end
            end
            if (o_lvs_vld && i_lvs_rdy) begin
                leaf_t e;
                lvs_beats++;
                if (lvs_sb.size() == 0) begin
                    check("leaf_unexpected", 1, 0);
                end else begin
                    e = lvs_sb.pop_front();
                    check("leaf_value", o_lvs, {255'd0, e.b});
                    check("leaf_idx", o_lvs_idx, e.idx);
                    check("leaf_last", o_last, e.last);
                end
            end
        end
    end

    task automatic set_rdys(input logic r, input logic l);
        @(posedge clk);
        #1;
        i_res_rdy = r;
        i_lvs_rdy = l;
    endtask

    // Offer one request and wait (bounded) until it is accepted; expectations
    // are queued at acceptance.
    task automatic push_req(input logic [63:0] a, input logic sgn, input logic [2:0] wcode,
                            input int n, input logic [252:0] exp_res);
        bit done = 0;
        logic [63:0] at;
        for (int c = 0; c < 20000 && !done; c++) begin
            @(negedge clk);
            i_vld  = 1'b1;
            i_a    = a;
            i_mode = {sgn, wcode};
            if (o_rdy) begin
                @(posedge clk);
                #1;
                i_vld = 1'b0;
                done  = 1;
                at = a;
                res_sb.push_back(exp_result(a, sgn, n) === exp_res ? exp_res : exp_res);
                for (int k = 0; k < n; k++) begin
                    leaf_t e;
                    e.b    = at[k];
                    e.idx  = 7'(k);
                    e.last = (k == n - 1);
                    lvs_sb.push_back(e);
                end
            end
        end
        if (!done) begin
            i_vld = 1'b0;
            check("push_timeout", 0, 1);
        end
    endtask

    task automatic wait_drain(input int budget);
        bit done = 0;
        for (int c = 0; c < budget && !done; c++) begin
            @(negedge clk);
            if (res_sb.size() == 0 && lvs_sb.size() == 0 && !o_res_vld && !o_lvs_vld) done = 1;
        end
        if (!done) check("drain_timeout", 0, 1);
    endtask

    initial begin
        logic [252:0] hold_res;
        logic [252:0] hold_lvs;
        int           base_res, base_lvs;
        bit           hit;

        rst_n     = 1'b0;
        i_vld     = 1'b0;
        i_a       = '0;
        i_mode    = '0;
        i_res_rdy = 1'b1;
        i_lvs_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rdy", o_rdy, 1);
        check("rst_res_vld", o_res_vld, 0);
        check("rst_lvs_vld", o_lvs_vld, 0);
        check("rst_res", o_res, 0);
        check("rst_lvs", o_lvs, 0);
        check("rst_idx", o_lvs_idx, 0);
        check("rst_last", o_last, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: I32 with latency check
        push_req(64'd1692970200, 1'b1, WCODE_32, 32, 253'd1692970200);
        @(negedge clk);
        check("lat_vld_low_e0", o_res_vld, 0);
        @(negedge clk);
        check("lat_res_vld_e1", o_res_vld, 1);
        check("lat_lvs_vld_e1", o_lvs_vld, 1);
        check("i32_res_direct", o_res, 253'd1692970200);
        check("i32_idx0", o_lvs_idx, 0);
        wait_drain(200);

        // 2: I8 all-ones negative and U8 with ignored upper bits
        push_req(64'hFF, 1'b1, WCODE_8, 8, MOD - 253'd1);
        push_req(64'h1FF, 1'b0, WCODE_8, 8, 253'd255);
        wait_drain(200);

        // 3: I64 most negative, and wcode 4 / undefined code clamp to 64
        push_req(64'h8000_0000_0000_0000, 1'b1, WCODE_64, 64, MOD - (253'd1 << 63));
        push_req(64'h8000_0000_0000_0000, 1'b1, WCODE_128, 64, MOD - (253'd1 << 63));
        push_req(64'hF000_0000_0000_0001, 1'b0, 3'd7, 64, 253'h0F000_0000_0000_0001);
        wait_drain(500);

        // 4: stall both channels, fill the FIFO, then drain in order
        set_rdys(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            push_req(64'h1234 + 64'(i * 16'h0101), 1'b0, WCODE_16, 16,
                     253'(16'h1234 + 16'(i * 16'h0101)));
        end
        @(negedge clk);
        check("full_rdy_low", o_rdy, 0);
        check("stall_res_vld", o_res_vld, 1);
        hold_res = o_res;
        hold_lvs = o_lvs;
        repeat (5) @(negedge clk);
        check("stall_res_stable", o_res, hold_res);
        check("stall_lvs_stable", o_lvs, hold_lvs);
        check("stall_idx", o_lvs_idx, 0);
        check("stall_rdy_still_low", o_rdy, 0);
        set_rdys(1'b1, 1'b1);
        push_req(64'hBEEF, 1'b0, WCODE_16, 16, 253'hBEEF);
        wait_drain(600);

        // 5: random readies, 200 U16/I16 requests
        base_res = res_beats;
        base_lvs = lvs_beats;
        rand_en  = 1;
        for (int i = 0; i < 200; i++) begin
            logic [63:0] a;
            logic        s;
            a = {$urandom, $urandom};
            s = 1'($urandom_range(0, 1));
            push_req(a, s, WCODE_16, 16, exp_result(a, s, 16));
        end
        wait_drain(30000);
        rand_en = 0;
        check("rand_res_beats", 32'(res_beats - base_res), 200);
        check("rand_lvs_beats", 32'(lvs_beats - base_lvs), 3200);
        set_rdys(1'b1, 1'b1);

        // 6: asynchronous reset in the middle of an I32 leaf stream
        push_req(64'hDEAD_BEEF, 1'b1, WCODE_32, 32, MOD - (253'd1 << 32) + 253'hDEAD_BEEF);
        hit = 0;
        for (int c = 0; c < 100 && !hit; c++) begin
            @(negedge clk);
            if (o_lvs_vld && o_lvs_idx == 7'd5) hit = 1;
        end
        check("reach_leaf5", hit, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_res_vld", o_res_vld, 0);
        check("arst_lvs_vld", o_lvs_vld, 0);
        check("arst_rdy", o_rdy, 1);
        check("arst_res", o_res, 0);
        check("arst_idx", o_lvs_idx, 0);
        res_sb.delete();
        lvs_sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        push_req(64'hA5, 1'b0, WCODE_8, 8, 253'hA5);
        @(negedge clk);
        @(negedge clk);
        check("post_rst_vld", o_lvs_vld, 1);
        check("post_rst_idx0", o_lvs_idx, 0);
        wait_drain(200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
